headlight_driver: RTL and testbench

HEADLIGHT_DRIVER -- requirements
Module: headlight_driver

---
 rtl/robot_pkg.sv | 16 +
 rtl/sync_debounce.sv | 50 +++++
 rtl/headlight_driver.sv | 136 +++++++++++++
 tb/tb_headlight_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// Shared definitions for robot sensor and lighting blocks: lamp FSM state
// encoding and default timing constants.
package robot_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } lamp_state_e;

    localparam logic [15:0] DEFAULT_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [15:0] DEFAULT_RAMP_DIV        = 16'd1000;
    localparam int          DEFAULT_PWM_BITS        = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debounce filter; dout only follows the
// synchronized input after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
module sync_debounce
    import robot_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic        sync1_q;
    logic        sync2_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        db_q;
    logic        db_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // Any sample that agrees with the accepted value restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/headlight_driver.sv
// Automatic headlight controller: debounced dark sensing, ramped brightness
// FSM and a free-running PWM output stage.
module headlight_driver
    import robot_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [15:0] RAMP_DIV        = DEFAULT_RAMP_DIV,
    parameter int          PWM_BITS        = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dark,
    input  logic                enable,
    output logic                led_pwm,
    output logic [PWM_BITS-1:0] level,
    output logic                lamp_on
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LEVEL_MIN = '0;

    logic                dark_db;
    logic                demand;
    logic                tick;
    lamp_state_e         state_q;
    lamp_state_e         state_d;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [15:0]         tick_cnt_q;
    logic [15:0]         tick_cnt_d;
    logic                led_pwm_q;
    logic                led_pwm_d;
    logic                lamp_on_q;
    logic                lamp_on_d;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dark_db (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (dark),
        .dout (dark_db)
    );

    assign demand = dark_db & enable;
    assign tick   = (tick_cnt_q >= RAMP_DIV - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            level_q    <= '0;
            pwm_cnt_q  <= '0;
            tick_cnt_q <= '0;
            led_pwm_q  <= 1'b0;
            lamp_on_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            pwm_cnt_q  <= pwm_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            led_pwm_q  <= led_pwm_d;
            lamp_on_q  <= lamp_on_d;
        end
    end

    // The tick counter only advances while ramping with no transition, so
    // every state change and every step restarts the RAMP_DIV interval.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        tick_cnt_d = '0;
        case (state_q)
            ST_OFF: begin
                if (demand) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_ON: begin
                if (!demand) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_UP: begin
                if (!demand) begin
                    state_d = ST_RAMP_DOWN;
                end else if (tick) begin
                    if (level_q != LEVEL_MAX) begin
                        level_d = level_q + 1'b1;
                    end
                    if (level_q >= LEVEL_MAX - 1'b1) begin
                        state_d = ST_ON;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 16'd1;
                end
            end
            ST_RAMP_DOWN: begin
                if (demand) begin
                    state_d = ST_RAMP_UP;
                end else if (tick) begin
                    if (level_q != LEVEL_MIN) begin
                        level_d = level_q - 1'b1;
                    end
                    if (level_q <= LEVEL_MIN + 1'b1) begin
                        state_d = ST_OFF;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Full and zero brightness are forced so the LED never glitches at the ends.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        if (level_q == LEVEL_MAX) begin
            led_pwm_d = 1'b1;
        end else if (level_q == LEVEL_MIN) begin
            led_pwm_d = 1'b0;
        end else begin
            led_pwm_d = (pwm_cnt_q < level_q);
        end
        lamp_on_d = (state_q == ST_ON);
    end

    assign led_pwm = led_pwm_q;
    assign level   = level_q;
    assign lamp_on = lamp_on_q;

endmodule

// File: tb/tb_headlight_driver.sv
// Self-checking bench for headlight_driver: a cycle-level behavioural model
// compared every cycle, plus hand-computed scenario expectations.
module tb_headlight_driver;

    localparam int DEB    = 4;
    localparam int DIV    = 2;
    localparam int LMAX   = 255;
    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_ON   = 2;
    localparam int M_DOWN = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       dark    = 1'b0;
    logic       enable  = 1'b0;
    logic       led_pwm;
    logic [7:0] level;
    logic       lamp_on;

    int errors = 0;
    int checks = 0;

    // Behavioural model state, all plain integers.
    int mS1    = 0;
    int mS2    = 0;
    int mDb    = 0;
    int mRun   = 0;
    int mMode  = M_OFF;
    int mLevel = 0;
    int mEntry = 0;
    int mEdges = 0;
    int mLed   = 0;
    int mLamp  = 0;
    int edgeNo;
    int pwmPrev;
    bit demand;
    bit stepDue;

    headlight_driver #(
        .DEBOUNCE_CYCLES(16'd4),
        .RAMP_DIV       (16'd2),
        .PWM_BITS       (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dark   (dark),
        .enable (enable),
        .led_pwm(led_pwm),
        .level  (level),
        .lamp_on(lamp_on)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic d, input logic e);
        dark   = d;
        enable = e;
    endtask

    // Waits (bounded) until level equals / differs from target; cyc = negedges waited.
    task automatic waitLevel(input string name, input int target, input bit wantEqual,
                             input int limit, output int cyc);
        cyc = 0;
        while (((int'(level) == target) != wantEqual) && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if ((int'(level) == target) != wantEqual) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timeout after %0d cycles, level=%0d target=%0d",
                     name, cyc, level, target);
        end
    endtask

    // Model: steps happen every DIV edges measured from the edge the current
    // state was entered; PWM phase is the number of edges since reset.
    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mS1 = 0; mS2 = 0; mDb = 0; mRun = 0; mMode = M_OFF;
                mLevel = 0; mEntry = 0; mEdges = 0; mLed = 0; mLamp = 0;
            end else begin
                edgeNo  = mEdges + 1;
                pwmPrev = mEdges % 256;
                if (mLevel == LMAX)   mLed = 1;
                else if (mLevel == 0) mLed = 0;
                else                  mLed = (pwmPrev < mLevel) ? 1 : 0;
                mLamp   = (mMode == M_ON) ? 1 : 0;
                demand  = (mDb == 1) && (enable == 1'b1);
                stepDue = ((edgeNo - mEntry) % DIV) == 0;
                case (mMode)
                    M_OFF: if (demand) begin mMode = M_UP; mEntry = edgeNo; end
                    M_ON:  if (!demand) begin mMode = M_DOWN; mEntry = edgeNo; end
                    M_UP: begin
                        if (!demand) begin
                            mMode = M_DOWN; mEntry = edgeNo;
                        end else if (stepDue) begin
                            if (mLevel < LMAX) mLevel++;
                            if (mLevel == LMAX) begin mMode = M_ON; mEntry = edgeNo; end
                        end
                    end
                    default: begin
                        if (demand) begin
                            mMode = M_UP; mEntry = edgeNo;
                        end else if (stepDue) begin
                            if (mLevel > 0) mLevel--;
                            if (mLevel == 0) begin mMode = M_OFF; mEntry = edgeNo; end
                        end
                    end
                endcase
                if (mS2 != mDb) begin
                    mRun++;
                    if (mRun == DEB) begin mDb = mS2; mRun = 0; end
                end else begin
                    mRun = 0;
                end
                mS2    = mS1;
                mS1    = int'(dark);
                mEdges = edgeNo;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            checkOutput("model_level",   32'(level),   mLevel);
            checkOutput("model_led_pwm", 32'(led_pwm), mLed);
            checkOutput("model_lamp_on", 32'(lamp_on), mLamp);
        end
    end

    initial begin : stimulus
        int cyc;
        int ones;
        int maxLevel;
        int badLevel;

        repeat (3) @(negedge clk);
        checkOutput("reset_level",   32'(level),   0);
        checkOutput("reset_led_pwm", 32'(led_pwm), 0);
        checkOutput("reset_lamp_on", 32'(lamp_on), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] scenario 1: short dark pulse");
        applyStimulus(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        repeat (12) @(negedge clk);
        checkOutput("s1_level_stays_0", 32'(level),   0);
        checkOutput("s1_lamp_off",      32'(lamp_on), 0);

        $display("[TB] scenario 2: ramp up to full");
        applyStimulus(1'b1, 1'b1);
        waitLevel("s2_first_step", 0, 1'b0, 40, cyc);
        checkOutput("s2_first_step_latency", cyc, 9);
        waitLevel("s2_full", LMAX, 1'b1, 1000, cyc);
        checkOutput("s2_ramp_cycles", cyc, 508);
        @(negedge clk);
        checkOutput("s2_lamp_on", 32'(lamp_on), 1);
        ones = 0;
        repeat (256) begin
            @(negedge clk);
            ones += int'(led_pwm);
        end
        checkOutput("s2_led_always_on", ones, 256);

        $display("[TB] scenario 3: ramp down to off");
        applyStimulus(1'b0, 1'b1);
        waitLevel("s3_empty", 0, 1'b1, 1000, cyc);
        checkOutput("s3_ramp_down_cycles", cyc, 517);
        @(negedge clk);
        ones = 0;
        repeat (256) begin
            @(negedge clk);
            ones += int'(led_pwm);
        end
        checkOutput("s3_led_always_off", ones, 0);
        checkOutput("s3_lamp_off", 32'(lamp_on), 0);

        $display("[TB] scenario 4: enable dropped at level 100");
        applyStimulus(1'b1, 1'b1);
        waitLevel("s4_reach_100", 100, 1'b1, 1000, cyc);
        applyStimulus(1'b1, 1'b0);
        maxLevel = int'(level);
        cyc = 0;
        while (level != 8'd0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (int'(level) > maxLevel) maxLevel = int'(level);
        end
        checkOutput("s4_max_level",   maxLevel,    100);
        checkOutput("s4_down_cycles", cyc,         201);
        checkOutput("s4_level_zero",  32'(level),  0);

        $display("[TB] scenario 5: hold level 128 and measure duty");
        applyStimulus(1'b1, 1'b1);
        waitLevel("s5_reach_128", 128, 1'b1, 1000, cyc);
        applyStimulus(1'b1, 1'b0);
        repeat (2) begin
            @(negedge clk);
            applyStimulus(1'b1, ~enable);
        end
        ones = 0;
        badLevel = 0;
        repeat (256) begin
            @(negedge clk);
            ones += int'(led_pwm);
            if (level != 8'd128) badLevel++;
            applyStimulus(1'b1, ~enable);
        end
        checkOutput("s5_level_held",  badLevel, 0);
        checkOutput("s5_duty_ones",   ones,     128);
        applyStimulus(1'b1, 1'b0);
        waitLevel("s5_drain", 0, 1'b1, 1000, cyc);

        $display("[TB] scenario 6: asynchronous reset at level 200");
        applyStimulus(1'b1, 1'b1);
        waitLevel("s6_reach_200", 200, 1'b1, 1000, cyc);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("s6_async_level",   32'(level),   0);
        checkOutput("s6_async_led_pwm", 32'(led_pwm), 0);
        checkOutput("s6_async_lamp_on", 32'(lamp_on), 0);
        @(negedge clk);
        rst_n = 1'b1;
        waitLevel("s6_rearm", 0, 1'b0, 40, cyc);
        checkOutput("s6_fresh_debounce_latency", cyc, 9);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
